// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: core widths, load/store aluop encodings, LSU state encoding and op-class helpers.
package mem_lsu_pkg;
  localparam int REG_BUS = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int ALU_OP_BUS = 8;
  localparam logic RST_ENABLE = 1'b0;
  localparam logic NO_STOP = 1'b0;
  localparam logic [ALU_OP_BUS-1:0] EXE_LB_OP  = 8'h20;
  localparam logic [ALU_OP_BUS-1:0] EXE_LH_OP  = 8'h21;
  localparam logic [ALU_OP_BUS-1:0] EXE_LW_OP  = 8'h22;
  localparam logic [ALU_OP_BUS-1:0] EXE_LBU_OP = 8'h23;
  localparam logic [ALU_OP_BUS-1:0] EXE_LHU_OP = 8'h24;
  localparam logic [ALU_OP_BUS-1:0] EXE_SB_OP  = 8'h25;
  localparam logic [ALU_OP_BUS-1:0] EXE_SH_OP  = 8'h26;
  localparam logic [ALU_OP_BUS-1:0] EXE_SW_OP  = 8'h27;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_BUSY = 2'b01, S_DONE = 2'b10} lsu_state_e;
  function automatic logic is_store(input logic [ALU_OP_BUS-1:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction
  function automatic logic is_mem(input logic [ALU_OP_BUS-1:0] op);
    return is_store(op) || (op inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP});
  endfunction
  function automatic logic is_byte(input logic [ALU_OP_BUS-1:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
  endfunction
  function automatic logic is_half(input logic [ALU_OP_BUS-1:0] op);
    return op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
  endfunction
  function automatic logic is_word(input logic [ALU_OP_BUS-1:0] op);
    return op inside {EXE_LW_OP, EXE_SW_OP};
  endfunction
endpackage

// File: rtl/mem_lsu_align.sv
// mem_align: byte-lane enables, store replication and load extraction/extension from op and addr[1:0].
module mem_align
  import mem_lsu_pkg::*;
(
  input  logic [ALU_OP_BUS-1:0] op,
  input  logic [1:0]            addr_lo,
  input  logic [REG_BUS-1:0]    st_data,
  input  logic [REG_BUS-1:0]    rdata,
  output logic [3:0]            sel,
  output logic [REG_BUS-1:0]    wdata,
  output logic [REG_BUS-1:0]    ld_data
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sel = is_byte(op) ? 4'b0001 << addr_lo : is_half(op) ? 4'b0011 << {addr_lo[1], 1'b0} : 4'b1111;
    wdata = is_byte(op) ? {4{st_data[7:0]}} : is_half(op) ? {2{st_data[15:0]}} : st_data;
    ld_data = op == EXE_LB_OP  ? {{24{b[7]}}, b} :
              op == EXE_LBU_OP ? {24'b0, b} :
              op == EXE_LH_OP  ? {{16{h[15]}}, h} :
              op == EXE_LHU_OP ? {16'b0, h} :
              op == EXE_LW_OP  ? rdata : '0;
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage with req/ack data bus and pipeline stall.
// MEM_MISALIGN_TRAP_EN: misaligned half/word ops skip the bus, suppress write-back and pulse misalign.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_BUS-1:0] ex_wd,
  input  logic                    ex_wreg,
  input  logic [REG_BUS-1:0]      ex_wdata,
  input  logic [ALU_OP_BUS-1:0]   ex_aluop,
  input  logic [REG_BUS-1:0]      ex_mem_addr,
  input  logic [REG_BUS-1:0]      ex_mem_data,
  input  logic [4:0]              stalled,
  input  logic [REG_BUS-1:0]      dbus_rdata,
  input  logic                    dbus_ack,
  output logic                    dbus_req,
  output logic                    dbus_we,
  output logic [REG_BUS-1:0]      dbus_addr,
  output logic [REG_BUS-1:0]      dbus_wdata,
  output logic [3:0]              dbus_sel,
  output logic [REG_ADDR_BUS-1:0] mem_wd,
  output logic                    mem_wreg,
  output logic [REG_BUS-1:0]      mem_wdata,
  output logic                    stallreq
`ifdef MEM_MISALIGN_TRAP_EN
  ,output logic                   misalign
`endif
);
  lsu_state_e state_q, state_d;
  logic req_q, req_d, we_q, we_d, mis_q, mis_d, pulse_q, pulse_d, mis, mem_op;
  logic [REG_BUS-1:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d, al_wdata, al_ld;
  logic [3:0] sel_q, sel_d, al_sel;
  logic [1:0] lo_q, lo_d, lo_eff, al_lo;
  logic [ALU_OP_BUS-1:0] op_q, op_d, al_op;
  logic unused_stall;
  assign unused_stall = ^{stalled[4], stalled[2:0]};
  mem_align u_align (
    .op(al_op), .addr_lo(al_lo), .st_data(ex_mem_data), .rdata(dbus_rdata),
    .sel(al_sel), .wdata(al_wdata), .ld_data(al_ld)
  );
  always_comb begin
    mem_op = is_mem(ex_aluop);
    lo_eff = is_half(ex_aluop) ? {ex_mem_addr[1], 1'b0} : is_word(ex_aluop) ? 2'b00 : ex_mem_addr[1:0];
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (is_half(ex_aluop) && ex_mem_addr[0]) || (is_word(ex_aluop) && |ex_mem_addr[1:0]);
`else
    mis = 1'b0;
`endif
    al_op = state_q == S_IDLE ? ex_aluop : op_q;
    al_lo = state_q == S_IDLE ? lo_eff : lo_q;
    state_d = state_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    sel_d = sel_q;
    lo_d = lo_q;
    op_d = op_q;
    data_d = data_q;
    mis_d = mis_q;
    pulse_d = 1'b0;
    mem_wd = ex_wd;
    mem_wreg = ex_wreg;
    mem_wdata = ex_wdata;
    stallreq = 1'b0;
    if (state_q == S_IDLE && mem_op) begin
      stallreq = 1'b1;
      state_d = mis ? S_DONE : S_BUSY;
      op_d = ex_aluop;
      lo_d = lo_eff;
      mis_d = mis;
      pulse_d = mis;
      data_d = '0;
      req_d = !mis;
      we_d = mis ? we_q : is_store(ex_aluop);
      addr_d = mis ? addr_q : {ex_mem_addr[31:2], 2'b00};
      sel_d = mis ? sel_q : al_sel;
      wdata_d = mis ? wdata_q : al_wdata;
    end else if (state_q == S_BUSY) begin
      stallreq = 1'b1;
      state_d = dbus_ack ? S_DONE : S_BUSY;
      req_d = !dbus_ack;
      data_d = dbus_ack ? al_ld : data_q;
    end else if (state_q == S_DONE) begin
      mem_wdata = data_q;
      mem_wreg = ex_wreg && !is_store(op_q) && !mis_q;
      state_d = stalled[3] == NO_STOP ? S_IDLE : S_DONE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= S_IDLE;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      sel_q <= 4'b0000;
      lo_q <= 2'b00;
      op_q <= '0;
      data_q <= '0;
      mis_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      sel_q <= sel_d;
      lo_q <= lo_d;
      op_q <= op_d;
      data_q <= data_d;
      mis_q <= mis_d;
      pulse_q <= pulse_d;
    end
  end
  assign dbus_req = req_q;
  assign dbus_we = we_q;
  assign dbus_addr = addr_q;
  assign dbus_wdata = wdata_q;
  assign dbus_sel = sel_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = pulse_q;
`else
  logic unused_pulse;
  assign unused_pulse = pulse_q;
`endif
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed-vector self-checking bench for mem_lsu.
module tb_mem_lsu;
  import mem_lsu_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] ex_wd = '0;
  logic ex_wreg = 1'b0, dbus_ack = 1'b0;
  logic [31:0] ex_wdata = '0, ex_mem_addr = '0, ex_mem_data = '0, dbus_rdata = '0;
  logic [7:0] ex_aluop = 8'h01;
  logic [4:0] stalled = '0;
  logic dbus_req, dbus_we, mem_wreg, stallreq;
  logic [31:0] dbus_addr, dbus_wdata, mem_wdata;
  logic [3:0] dbus_sel;
  logic [4:0] mem_wd;
`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
`endif
  int n_tests = 0, n_fail = 0, n_stall;
  logic [31:0] s_addr, s_wdata, d_wdata;
  logic [3:0] s_sel;
  logic s_we, d_wreg, req_seen, d_mis, done;

  mem_lsu dut (
    .clk(clk), .rst(rst), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_mem_data(ex_mem_data),
    .stalled(stalled), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_sel(dbus_sel), .mem_wd(mem_wd),
    .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .stallreq(stallreq)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nop(input logic [31:0] wdata);
    @(posedge clk);
    #1;
    ex_aluop = 8'h01;
    ex_wd = 5'd3;
    ex_wreg = 1'b1;
    ex_wdata = wdata;
  endtask

  // Drives one memory op and returns at the falling edge of its first DONE cycle.
  task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int waits);
    int busy;
    busy = 0;
    n_stall = 0;
    req_seen = 1'b0;
    done = 1'b0;
    d_mis = 1'b0;
    @(posedge clk);
    #1;
    ex_aluop = op;
    ex_mem_addr = addr;
    ex_mem_data = rs2;
    ex_wd = 5'd7;
    ex_wreg = 1'b1;
    ex_wdata = 32'hDEAD_0000;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stallreq) n_stall++;
      if (dbus_req) begin
        req_seen = 1'b1;
        s_addr = dbus_addr;
        s_sel = dbus_sel;
        s_we = dbus_we;
        s_wdata = dbus_wdata;
        busy++;
        if (busy == waits + 1) begin
          dbus_ack = 1'b1;
          dbus_rdata = rdata;
        end
      end else if (!stallreq) begin
        done = 1'b1;
        d_wdata = mem_wdata;
        d_wreg = mem_wreg;
`ifdef MEM_MISALIGN_TRAP_EN
        d_mis = misalign;
`endif
        break;
      end
      @(posedge clk);
      #1;
      dbus_ack = 1'b0;
    end
    check("op_done", {31'b0, done}, 32'd1);
  endtask

  initial begin
    logic any_req;
    ex_wdata = 32'hCAFE;
    ex_wreg = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'b0, dbus_req}, 32'd0);
    check("rst_we", {31'b0, dbus_we}, 32'd0);
    check("rst_addr", dbus_addr, 32'd0);
    check("rst_wdata", dbus_wdata, 32'd0);
    check("rst_sel", {28'b0, dbus_sel}, 32'd0);
    check("rst_stall", {31'b0, stallreq}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'hCAFE);
    rst = 1'b1;

    @(posedge clk);
    #1;
    ex_aluop = 8'h01;
    ex_wd = 5'd5;
    ex_wdata = 32'h1234;
    #1;
    check("alu_wdata", mem_wdata, 32'h1234);
    check("alu_wd", {27'b0, mem_wd}, 32'd5);
    check("alu_stall", {31'b0, stallreq}, 32'd0);
    any_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_req |= dbus_req;
    end
    check("alu_no_req", {31'b0, any_req}, 32'd0);

    run_mem(EXE_LB_OP, 32'h1003, 32'h0, 32'h80AA_BBCC, 0);
    check("lb_addr", s_addr, 32'h1000);
    check("lb_sel", {28'b0, s_sel}, 32'h8);
    check("lb_we", {31'b0, s_we}, 32'd0);
    check("lb_stalls", n_stall, 32'd2);
    check("lb_data", d_wdata, 32'hFFFF_FF80);
    check("lb_wreg", {31'b0, d_wreg}, 32'd1);
    nop(32'h0);

    run_mem(EXE_LHU_OP, 32'h2002, 32'h0, 32'h8001_0000, 3);
    check("lhu_addr", s_addr, 32'h2000);
    check("lhu_sel", {28'b0, s_sel}, 32'hC);
    check("lhu_stalls", n_stall, 32'd5);
    check("lhu_data", d_wdata, 32'h0000_8001);
    stalled = 5'b01000;
    @(posedge clk);
    @(negedge clk);
    check("hold_stall", {31'b0, stallreq}, 32'd0);
    check("hold_data", mem_wdata, 32'h0000_8001);
    stalled = 5'b00000;
    nop(32'h0);

    run_mem(EXE_LH_OP, 32'h2002, 32'h0, 32'h8001_0000, 1);
    check("lh_stalls", n_stall, 32'd3);
    check("lh_data", d_wdata, 32'hFFFF_8001);
    nop(32'h0);

    run_mem(EXE_SB_OP, 32'h0001, 32'h0000_00EE, 32'h1111_1111, 0);
    check("sb_we", {31'b0, s_we}, 32'd1);
    check("sb_sel", {28'b0, s_sel}, 32'h2);
    check("sb_wdata", s_wdata, 32'hEEEE_EEEE);
    check("sb_wreg", {31'b0, d_wreg}, 32'd0);
    check("sb_data", d_wdata, 32'd0);
    nop(32'h0);

    run_mem(EXE_SH_OP, 32'h0042, 32'h1234_ABCD, 32'h0, 0);
    check("sh_sel", {28'b0, s_sel}, 32'hC);
    check("sh_wdata", s_wdata, 32'hABCD_ABCD);
    nop(32'h0);

    run_mem(EXE_LW_OP, 32'h0006, 32'h0, 32'h1234_5678, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("lw_mis_req", {31'b0, req_seen}, 32'd0);
    check("lw_mis_pulse", {31'b0, d_mis}, 32'd1);
    check("lw_mis_wreg", {31'b0, d_wreg}, 32'd0);
    nop(32'h0);
    #1;
    check("lw_mis_pulse_end", {31'b0, misalign}, 32'd0);
`else
    check("lw_addr", s_addr, 32'h0004);
    check("lw_sel", {28'b0, s_sel}, 32'hF);
    check("lw_data", d_wdata, 32'h1234_5678);
    nop(32'h0);
`endif

    @(posedge clk);
    #1;
    ex_aluop = EXE_LW_OP;
    ex_mem_addr = 32'h3000;
    ex_wreg = 1'b1;
    @(posedge clk);
    #1;
    check("rb_req", {31'b0, dbus_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rb_req_drop", {31'b0, dbus_req}, 32'd0);
    ex_aluop = 8'h01;
    ex_wdata = 32'h5555;
    #1;
    check("rb_idle", mem_wdata, 32'h5555);
    @(posedge clk);
    #1;
    rst = 1'b1;
    dbus_ack = 1'b1;
    dbus_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    dbus_ack = 1'b0;
    @(negedge clk);
    check("rb_ack_req", {31'b0, dbus_req}, 32'd0);
    check("rb_ack_stall", {31'b0, stallreq}, 32'd0);
    check("rb_ack_data", mem_wdata, 32'h5555);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
